// File: rtl/dual_issue_hazard_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_hazard_scheduler_if
// Description : Decode-to-issue bundle: decoded pair, backend control and
//               issue decisions.
// Revision    : 1.0
// ============================================================================
interface dual_issue_hazard_scheduler_if;
    logic        i_pair_valid;
    logic        i_instr2_valid;
    logic [4:0]  i_rs1_addr_instr1;
    logic [4:0]  i_rs2_addr_instr1;
    logic [4:0]  i_rs1_addr_instr2;
    logic [4:0]  i_rs2_addr_instr2;
    logic [4:0]  i_rd_addr_instr1;
    logic [4:0]  i_rd_addr_instr2;
    logic        i_rd_we_instr1;
    logic        i_rd_we_instr2;
    logic [1:0]  i_unit_instr1;
    logic [1:0]  i_unit_instr2;
    logic        i_hold;
    logic        i_flush;
    logic        o_issue_instr1;
    logic        o_issue_instr2;
    logic [31:0] o_stall_cnt;

    modport master (
        output i_pair_valid, i_instr2_valid,
        output i_rs1_addr_instr1, i_rs2_addr_instr1,
        output i_rs1_addr_instr2, i_rs2_addr_instr2,
        output i_rd_addr_instr1, i_rd_addr_instr2,
        output i_rd_we_instr1, i_rd_we_instr2,
        output i_unit_instr1, i_unit_instr2,
        output i_hold, i_flush,
        input  o_issue_instr1, o_issue_instr2, o_stall_cnt
    );

    modport slave (
        input  i_pair_valid, i_instr2_valid,
        input  i_rs1_addr_instr1, i_rs2_addr_instr1,
        input  i_rs1_addr_instr2, i_rs2_addr_instr2,
        input  i_rd_addr_instr1, i_rd_addr_instr2,
        input  i_rd_we_instr1, i_rd_we_instr2,
        input  i_unit_instr1, i_unit_instr2,
        input  i_hold, i_flush,
        output o_issue_instr1, o_issue_instr2, o_stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dual_issue_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_hazard_scheduler
// Description : Dual-issue RAW scheduler with a 32-entry countdown scoreboard.
//               Optional stall counter: DUAL_ISSUE_STALL_CNT_EN.
// Revision    : 1.0
// ============================================================================
module dual_issue_hazard_scheduler #(
    parameter int unsigned ALU_LAT = 0,
    parameter int unsigned BRU_LAT = 0,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 3
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst_n,
    dual_issue_hazard_scheduler_if.slave bus
);

    localparam logic [1:0] c_UNIT_ALU = 2'b00;
    localparam logic [1:0] c_UNIT_BRU = 2'b01;

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];

    logic w_src1_ok;
    logic w_src2_ok;
    logic w_raw12;
    logic w_mem2;
    logic w_ready1;
    logic w_issue2;

    function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] unit);
        case (unit)
            c_UNIT_ALU: lat_of = CNT_W'(ALU_LAT);
            c_UNIT_BRU: lat_of = CNT_W'(BRU_LAT);
            default:    lat_of = CNT_W'(MEM_LAT);
        endcase
    endfunction

    // cnt_q[0] is pinned to zero, so x0 always reads as ready.
    assign w_src1_ok = (cnt_q[bus.i_rs1_addr_instr1] == '0) &&
                       (cnt_q[bus.i_rs2_addr_instr1] == '0);
    assign w_src2_ok = (cnt_q[bus.i_rs1_addr_instr2] == '0) &&
                       (cnt_q[bus.i_rs2_addr_instr2] == '0);
    assign w_raw12   = bus.i_rd_we_instr1 && (bus.i_rd_addr_instr1 != 5'd0) &&
                       ((bus.i_rd_addr_instr1 == bus.i_rs1_addr_instr2) ||
                        (bus.i_rd_addr_instr1 == bus.i_rs2_addr_instr2));
    // Units 10 and 11 both occupy the single memory port.
    assign w_mem2    = bus.i_unit_instr1[1] && bus.i_unit_instr2[1];

    assign w_ready1  = i_rst_n && bus.i_pair_valid && !bus.i_hold &&
                       !bus.i_flush && w_src1_ok;
    assign w_issue2  = w_ready1 && bus.i_instr2_valid && w_src2_ok &&
                       !w_raw12 && !w_mem2;

    assign bus.o_issue_instr1 = w_ready1;
    assign bus.o_issue_instr2 = w_issue2;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (bus.i_flush) begin
            for (int r = 0; r < 32; r++) begin
                cnt_d[r] = '0;
            end
        end else if (!bus.i_hold) begin
            for (int r = 0; r < 32; r++) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
            // Slot 2 is applied last so the younger writer wins a shared rd.
            if (w_ready1 && bus.i_rd_we_instr1) begin
                cnt_d[bus.i_rd_addr_instr1] = lat_of(bus.i_unit_instr1);
            end
            if (w_issue2 && bus.i_rd_we_instr2) begin
                cnt_d[bus.i_rd_addr_instr2] = lat_of(bus.i_unit_instr2);
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef DUAL_ISSUE_STALL_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (bus.i_pair_valid && !bus.i_hold && !bus.i_flush &&
            !w_ready1 && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.o_stall_cnt = stall_q;
`else
    assign bus.o_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_hazard_scheduler
// Description : Directed self-checking bench for dual_issue_hazard_scheduler.
// Revision    : 1.0
// ============================================================================
module tb_dual_issue_hazard_scheduler;

`ifdef DUAL_ISSUE_STALL_CNT_EN
    localparam bit c_STALL_EN = 1'b1;
`else
    localparam bit c_STALL_EN = 1'b0;
`endif

    localparam logic [1:0] c_ALU = 2'b00;
    localparam logic [1:0] c_MEM = 2'b10;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    dual_issue_hazard_scheduler_if bus ();

    dual_issue_hazard_scheduler #(
        .ALU_LAT (0),
        .BRU_LAT (0),
        .MEM_LAT (2),
        .CNT_W   (3)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic pv, input logic hold, input logic flush,
                         input logic [4:0] a1, input logic [4:0] b1,
                         input logic [4:0] d1, input logic we1, input logic [1:0] u1,
                         input logic v2,
                         input logic [4:0] a2, input logic [4:0] b2,
                         input logic [4:0] d2, input logic we2, input logic [1:0] u2);
        bus.i_pair_valid      = pv;
        bus.i_hold            = hold;
        bus.i_flush           = flush;
        bus.i_rs1_addr_instr1 = a1;
        bus.i_rs2_addr_instr1 = b1;
        bus.i_rd_addr_instr1  = d1;
        bus.i_rd_we_instr1    = we1;
        bus.i_unit_instr1     = u1;
        bus.i_instr2_valid    = v2;
        bus.i_rs1_addr_instr2 = a2;
        bus.i_rs2_addr_instr2 = b2;
        bus.i_rd_addr_instr2  = d2;
        bus.i_rd_we_instr2    = we2;
        bus.i_unit_instr2     = u2;
    endtask

    // Single instruction in slot 1, slot 2 empty.
    task automatic single(input logic hold, input logic flush,
                          input logic [4:0] a1, input logic [4:0] b1,
                          input logic [4:0] d1, input logic we1, input logic [1:0] u1);
        drive(1'b1, hold, flush, a1, b1, d1, we1, u1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, c_ALU);
    endtask

    task automatic check_issue(input string tag, input logic e1, input logic e2);
        tests++;
        assert (bus.o_issue_instr1 === e1) else begin
            fails++;
            $error("FAIL %s issue1: observed %b expected %b", tag, bus.o_issue_instr1, e1);
        end
        tests++;
        assert (bus.o_issue_instr2 === e2) else begin
            fails++;
            $error("FAIL %s issue2: observed %b expected %b", tag, bus.o_issue_instr2, e2);
        end
    endtask

    task automatic check_stall(input string tag, input logic [31:0] exp_en);
        logic [31:0] exp_v;
        exp_v = c_STALL_EN ? exp_en : 32'd0;
        tests++;
        assert (bus.o_stall_cnt === exp_v) else begin
            fails++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, bus.o_stall_cnt, exp_v);
        end
    endtask

    // Drive at the falling edge, sample 1 ns later, well clear of the rising edge.
    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset state: a ready pair must not issue while reset is low.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5, 1'b1, c_ALU,
              1'b1, 5'd3, 5'd4, 5'd6, 1'b1, c_ALU);
        #1;
        check_issue("reset", 1'b0, 1'b0);
        check_stall("reset", 32'd0);
        step; rst_n = 1'b1;

        // Independent ALU pair.
        #1 check_issue("indep", 1'b1, 1'b1);

        // Intra-pair RAW, then shifted instr issues back-to-back.
        step; drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd7, 1'b1, c_ALU,
                    1'b1, 5'd7, 5'd2, 5'd8, 1'b1, c_ALU);
        #1 check_issue("raw12", 1'b1, 1'b0);
        step; single(1'b0, 1'b0, 5'd7, 5'd2, 5'd8, 1'b1, c_ALU);
        #1 check_issue("raw12_shift", 1'b1, 1'b0);

        // Two memory ops cannot dual-issue.
        step; drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, c_MEM,
                    1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 2'b11);
        #1 check_issue("mem2", 1'b1, 1'b0);

        // Load-use: two bubbles.
        step; single(1'b0, 1'b0, 5'd1, 5'd2, 5'd9, 1'b1, c_MEM);
        #1 check_issue("ld_issue", 1'b1, 1'b0);
        step; single(1'b0, 1'b0, 5'd1, 5'd9, 5'd13, 1'b1, c_ALU);
        #1 check_issue("ld_use_n1", 1'b0, 1'b0);
        step; #1 check_issue("ld_use_n2", 1'b0, 1'b0);
        step; #1 check_issue("ld_use_n3", 1'b1, 1'b0);
        check_stall("ld_use", 32'd2);

        // Slot 2 blocked by a busy scoreboard entry.
        step; single(1'b0, 1'b0, 5'd1, 5'd2, 5'd14, 1'b1, c_MEM);
        #1 check_issue("busy2_prod", 1'b1, 1'b0);
        step; drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd15, 1'b1, c_ALU,
                    1'b1, 5'd14, 5'd2, 5'd16, 1'b1, c_ALU);
        #1 check_issue("busy2", 1'b1, 1'b0);
        step; drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, c_ALU,
                    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, c_ALU);
        #1 check_issue("idle", 1'b0, 1'b0);

        // Hold freezes the countdown.
        step; single(1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, c_MEM);
        #1 check_issue("hold_prod", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step; single(1'b1, 1'b0, 5'd3, 5'd2, 5'd17, 1'b1, c_ALU);
            #1 check_issue("hold_frz", 1'b0, 1'b0);
        end
        step; single(1'b0, 1'b0, 5'd3, 5'd2, 5'd17, 1'b1, c_ALU);
        #1 check_issue("hold_w1", 1'b0, 1'b0);
        step; #1 check_issue("hold_w2", 1'b0, 1'b0);
        step; #1 check_issue("hold_go", 1'b1, 1'b0);
        check_stall("hold", 32'd4);

        // Flush clears the scoreboard and blocks issue that cycle.
        step; single(1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, c_MEM);
        #1 check_issue("flush_prod", 1'b1, 1'b0);
        step; single(1'b0, 1'b1, 5'd3, 5'd2, 5'd18, 1'b1, c_ALU);
        #1 check_issue("flush_cyc", 1'b0, 1'b0);
        step; single(1'b0, 1'b0, 5'd3, 5'd2, 5'd18, 1'b1, c_ALU);
        #1 check_issue("flush_after", 1'b1, 1'b0);
        check_stall("flush", 32'd4);

        // Same rd in a pair: the MEM latency from slot 2 wins.
        step; drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10, 1'b1, c_ALU,
                    1'b1, 5'd3, 5'd4, 5'd10, 1'b1, c_MEM);
        #1 check_issue("samerd", 1'b1, 1'b1);
        step; single(1'b0, 1'b0, 5'd10, 5'd2, 5'd19, 1'b1, c_ALU);
        #1 check_issue("samerd_w1", 1'b0, 1'b0);
        step; #1 check_issue("samerd_w2", 1'b0, 1'b0);
        step; #1 check_issue("samerd_go", 1'b1, 1'b0);
        check_stall("samerd", 32'd6);

        // x0 is never busy and never forms an intra-pair RAW.
        step; single(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, c_MEM);
        #1 check_issue("x0_prod", 1'b1, 1'b0);
        step; single(1'b0, 1'b0, 5'd0, 5'd0, 5'd20, 1'b1, c_ALU);
        #1 check_issue("x0_cons", 1'b1, 1'b0);
        step; drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, c_ALU,
                    1'b1, 5'd0, 5'd0, 5'd21, 1'b1, c_ALU);
        #1 check_issue("x0_pair", 1'b1, 1'b1);

        // Asynchronous reset in mid-countdown.
        step; single(1'b0, 1'b0, 5'd1, 5'd2, 5'd9, 1'b1, c_MEM);
        #1 check_issue("arst_prod", 1'b1, 1'b0);
        step; single(1'b0, 1'b0, 5'd9, 5'd2, 5'd22, 1'b1, c_ALU);
        #1 check_issue("arst_w1", 1'b0, 1'b0);
        step; rst_n = 1'b0;
        #1 check_issue("arst_low", 1'b0, 1'b0);
        check_stall("arst_low", 32'd0);
        #2 rst_n = 1'b1;
        #1 check_issue("arst_rel", 1'b1, 1'b0);
        check_stall("arst_rel", 32'd0);

        step; drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, c_ALU,
                    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, c_ALU);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dual_issue_hazard_scheduler.md
# dual_issue_hazard_scheduler

Issue-stage scheduler for the dual-issue RV32I core. It holds a 32-entry per-register readiness scoreboard of countdown counters and decides each cycle whether to issue both instructions of the decoded pair, only instruction 1, or neither. Issue is allowed only when every source operand is either in the register file or reachable through the forwarding network (ALU/BRU/MEM result buffers). It sits between decode and the execution units, upstream of the forwarding unit whose select vectors it guarantees are resolvable.

## Interface
- ALU_LAT, 0, stall cycles a dependent must wait after an ALU producer issues
- BRU_LAT, 0, same for BRU producers
- MEM_LAT, 2, same for MEM (load) producers; every *_LAT is in 0..7
- CNT_W, 3, counter width; must hold max(*_LAT)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_pair_valid  in  1  decode presents a valid pair (instr 2 may be invalid)
- i_instr2_valid  in  1  slot 2 holds a real instruction
- i_rs1_addr_instr1, i_rs2_addr_instr1, i_rs1_addr_instr2, i_rs2_addr_instr2  in  5 each  source addresses
- i_rd_addr_instr1, i_rd_addr_instr2  in  5 each  destination addresses
- i_rd_we_instr1, i_rd_we_instr2  in  1 each  destination written
- i_unit_instr1, i_unit_instr2  in  2 each  00 ALU, 01 BRU, 10 MEM, 11 treated as MEM
- i_hold  in  1  backend back-pressure: no issue, counters frozen
- i_flush  in  1  mispredict/exception flush
- o_issue_instr1  out  1  instr 1 issues this cycle
- o_issue_instr2  out  1  instr 2 issues this cycle
- o_stall_cnt  out  32  stall counter (only with the configuration macro)

## Operation
- Scoreboard: cnt[r], r = 1..31, CNT_W bits; x0 is never busy, and writes to x0 are ignored. Source r is ready when cnt[r] == 0.
- ready1 = i_pair_valid & !i_hold & !i_flush & both instr1 sources ready.
- o_issue_instr1 = ready1.
- o_issue_instr2 = ready1 & i_instr2_valid & both instr2 sources ready & !raw12 & !mem2.
  - raw12: i_rd_we_instr1, rd1 != 0, and rd1 equals rs1 or rs2 of instr2.
  - mem2: both units are MEM (single memory port).
- On issue with rd_we and rd != 0: cnt[rd] <= LAT of that unit.
- All other nonzero counters decrement by 1 per cycle, except under i_hold, where they are frozen.
- Simultaneous events:
  - An issue load overrides a decrement of the same entry.
  - If both issued instructions share rd, instr 2's latency wins (younger writer).
- Priority: i_flush > i_hold > normal.
  - Flush clears every counter to 0 on that edge, and no issue occurs in that cycle.
- After a slot-1-only issue, decode shifts instr 2 into slot 1; the scheduler keeps no pair state.

## Timing
- Decisions are combinational from the registered scoreboard and current inputs; the scoreboard updates at the rising edge.
- MEM producer issued at cycle N with MEM_LAT=2: cnt is 2 at N+1, 1 at N+2, 0 at N+3. The dependent issues at N+3, giving 2 bubbles.
- With LAT=0, the dependent issues at N+1 (back-to-back via forwarding).
- Reset (asynchronous, any time, including mid-countdown): all counters 0; o_stall_cnt 0. o_issue_* are 0 while i_rst_n is low.
- Outputs are 0 whenever i_pair_valid is 0.

## Configuration
- DUAL_ISSUE_STALL_CNT_EN defined:
  - o_stall_cnt counts cycles with i_pair_valid=1, i_hold=0, i_flush=0 and o_issue_instr1=0.
  - The count saturates at 0xFFFF_FFFF and is cleared only by reset.
- Not defined: the port still exists, tied to 0, and no counter logic is built.

## Test plan
- Independent pair: rs1/rs2 of both instructions are x1..x4, rd1=x5, rd2=x6, both ALU, empty scoreboard -> o_issue_instr1=1 and o_issue_instr2=1 in the same cycle.
- Intra-pair RAW: instr1 rd=x7 (ALU), instr2 rs1=x7 -> cycle N issue1=1/issue2=0; shifted pair at N+1 issues.
- Load-use: MEM rd=x9 issued at N, consumer rs2=x9 presented from N+1 -> issue only at N+3. With the macro defined, o_stall_cnt=2.
- Hold and flush:
  - MEM rd=x3 issued, then i_hold for 4 cycles -> the consumer still waits 2 unheld cycles.
  - i_flush at N+1 -> a consumer of x3 issues at N+2.
- Same-rd pair and x0:
  - ALU rd=x10 with MEM rd=x10 -> cnt[x10]=2, and the consumer waits 2 cycles.
  - Producer rd=x0 -> a consumer of x0 is never stalled.
- Asynchronous reset asserted mid-countdown (cnt[x9]=1) -> after release, a consumer of x9 issues immediately and o_stall_cnt=0.
